// File: rtl/seg8_disp_sched.sv
// Digit refresh pacing, blanking and score/message arbitration
// for the shared 8-digit multiplexed 7-segment display.
module seg8_disp_sched #(
  parameter int CLK_DIV    = 1000,
  parameter int BLANK_CYC  = 50,
  parameter int MSG_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] score_val,
  input  logic [31:0] msg_val,
  input  logic        msg_req,
  input  logic        msg_abort,
  output logic        msg_ack,
  output logic        msg_done,
  output logic        msg_active,
  output logic [2:0]  digit_sel,
  output logic [3:0]  digit_val,
  output logic        digit_en
);

  localparam int PW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    SCORE,
    PEND,
    MSG,
    HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [2:0]    sel_nxt;
  logic [3:0]    val_nxt;
  logic          en_nxt;
  logic [31:0]   snap, snap_nxt;
  logic [7:0]    frames, frames_nxt;
  logic          abort_seen, abort_nxt;
  logic          ack_nxt, done_nxt, active_nxt;
  logic          tick, bound;

  assign tick  = presc == PW'(CLK_DIV - 1);
  assign bound = tick && (digit_sel == 3'd7);

  always_comb begin
    state_nxt  = state;
    frames_nxt = frames;
    snap_nxt   = snap;
    abort_nxt  = abort_seen;
    ack_nxt    = 1'b0;
    done_nxt   = 1'b0;
    active_nxt = msg_active;
    presc_nxt  = tick ? '0 : presc + 1'b1;
    sel_nxt    = tick ? digit_sel + 3'd1 : digit_sel;
    en_nxt     = presc_nxt >= PW'(BLANK_CYC);
    unique case (state)
      SCORE: begin
        if (msg_req) state_nxt = PEND;
        if (bound) snap_nxt = score_val;
      end
      PEND: begin
        if (!msg_req) begin
          state_nxt = SCORE;
          if (bound) snap_nxt = score_val;
        end else if (bound) begin
          snap_nxt   = msg_val;
          ack_nxt    = 1'b1;
          active_nxt = 1'b1;
          frames_nxt = 8'(MSG_FRAMES);
          abort_nxt  = 1'b0;
          state_nxt  = MSG;
        end
      end
      MSG: begin
        if (msg_abort) abort_nxt = 1'b1;
        if (bound) begin
          abort_nxt  = 1'b0;
          frames_nxt = frames - 8'd1;
          // abort and final count collapse into one ending
          if (frames <= 8'd1 || abort_seen || msg_abort) begin
            snap_nxt   = score_val;
            done_nxt   = 1'b1;
            active_nxt = 1'b0;
            frames_nxt = '0;
            state_nxt  = HOLD;
          end else begin
            snap_nxt = msg_val;
          end
        end
      end
      HOLD: begin
        if (!msg_req) state_nxt = SCORE;
        if (bound) snap_nxt = score_val;
      end
      default: state_nxt = SCORE;
    endcase
    val_nxt = snap_nxt[{sel_nxt, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SCORE;
      presc      <= '0;
      frames     <= '0;
      snap       <= '0;
      abort_seen <= 1'b0;
      digit_sel  <= '0;
      digit_val  <= '0;
      digit_en   <= 1'b0;
      msg_ack    <= 1'b0;
      msg_done   <= 1'b0;
      msg_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      frames     <= frames_nxt;
      snap       <= snap_nxt;
      abort_seen <= abort_nxt;
      digit_sel  <= sel_nxt;
      digit_val  <= val_nxt;
      digit_en   <= en_nxt;
      msg_ack    <= ack_nxt;
      msg_done   <= done_nxt;
      msg_active <= active_nxt;
    end
  end

endmodule

// File: tb/tb_seg8_disp_sched.sv
// Scoreboard bench for seg8_disp_sched: stimulus queues expected
// frames, a monitor pops one per frame and checks every slot.
module tb_seg8_disp_sched;

  localparam logic [31:0] S  = 32'h87654321;
  localparam logic [31:0] S2 = 32'h13579BDF;
  localparam logic [31:0] A  = 32'hAAAAAAAA;
  localparam logic [31:0] M2 = 32'hFEDCBA98;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] score_val, msg_val;
  logic        msg_req, msg_abort;
  logic        msg_ack, msg_done, msg_active;
  logic [2:0]  digit_sel;
  logic [3:0]  digit_val;
  logic        digit_en;

  typedef struct {
    logic [31:0] data;
    logic        ack;
    logic        done;
    logic        act;
  } frm_t;

  frm_t exp_q[$];
  frm_t cur;
  bit   have_cur = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  seg8_disp_sched #(
    .CLK_DIV(4), .BLANK_CYC(1), .MSG_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .score_val(score_val), .msg_val(msg_val),
    .msg_req(msg_req), .msg_abort(msg_abort),
    .msg_ack(msg_ack), .msg_done(msg_done),
    .msg_active(msg_active),
    .digit_sel(digit_sel), .digit_val(digit_val),
    .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %h expected %h",
                  nm, cyc, act, exp);
  endtask

  task automatic push(input logic [31:0] d, input logic a,
                      input logic dn, input logic ac);
    frm_t f;
    f.data = d; f.ack = a; f.done = dn; f.act = ac;
    exp_q.push_back(f);
  endtask

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) chk("wait_timeout", cyc, n);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"}, 32'(digit_sel), 0);
    chk({tag, "_val"}, 32'(digit_val), 0);
    chk({tag, "_en"}, 32'(digit_en), 0);
    chk({tag, "_ack"}, 32'(msg_ack), 0);
    chk({tag, "_done"}, 32'(msg_done), 0);
    chk({tag, "_active"}, 32'(msg_active), 0);
  endtask

  // monitor: frame = 32 cycles, slot = 4 cycles, blank = 1 cycle
  always @(negedge clk) begin
    int ph, sl, sp;
    logic [31:0] d;
    if (!rst) begin
      have_cur = 0;
    end else begin
      ph = cyc % 32;
      sl = ph / 4;
      sp = ph % 4;
      if (ph == 0 || !have_cur) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", 32'(exp_q.size()), 1);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
        end
        if (ph == 0) begin
          chk("ack_at_boundary", 32'(msg_ack), 32'(cur.ack));
          chk("done_at_boundary", 32'(msg_done), 32'(cur.done));
        end
      end else begin
        chk("ack_off_boundary", 32'(msg_ack), 0);
        chk("done_off_boundary", 32'(msg_done), 0);
      end
      if (sp == 0) begin
        d = cur.data;
        chk("digit_sel", 32'(digit_sel), 32'(sl));
        chk("digit_val", 32'(digit_val), 32'(d[sl*4 +: 4]));
        chk("digit_en_blank", 32'(digit_en), 0);
        chk("msg_active", 32'(msg_active), 32'(cur.act));
      end else begin
        chk("digit_en_drive", 32'(digit_en), 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    score_val = S;
    msg_val = A;
    msg_req = 1'b0;
    msg_abort = 1'b0;
    #23;
    chk_reset_vals("rst0");
    push(32'h0, 0, 0, 0);  // F0
    push(S,     0, 0, 0);  // F1
    push(S,     0, 0, 0);  // F2
    push(A,     1, 0, 1);  // F3 granted
    push(M2,    0, 0, 1);  // F4 animated
    push(S,     0, 1, 0);  // F5 count expired
    push(S2,    0, 0, 0);  // F6 held
    push(A,     1, 0, 1);  // F7 re-granted
    push(S2,    0, 1, 0);  // F8 aborted
    push(S2,    0, 0, 0);  // F9
    push(S2,    0, 0, 0);  // F10 withdrawn request
    push(S2,    0, 0, 0);  // F11
    push(A,     1, 0, 1);  // F12 granted then reset
    @(negedge clk);
    #1 rst = 1'b1;

    wait_cyc(74);  msg_req = 1'b1;
    wait_cyc(110); msg_val = M2;
    wait_cyc(170); score_val = S2;
    wait_cyc(197); msg_req = 1'b0;
    wait_cyc(200); msg_req = 1'b1; msg_val = A;
    wait_cyc(230); msg_abort = 1'b1;
    wait_cyc(231); msg_abort = 1'b0;
    wait_cyc(260); msg_req = 1'b0;
    wait_cyc(296); msg_req = 1'b1;
    wait_cyc(300); msg_req = 1'b0;
    wait_cyc(305); msg_abort = 1'b1;
    wait_cyc(306); msg_abort = 1'b0;
    wait_cyc(356); msg_req = 1'b1;
    wait_cyc(390);
    chk("active_before_reset", 32'(msg_active), 1);
    #2 rst = 1'b0;
    exp_q.delete();
    #1 chk_reset_vals("rst_mid");

    repeat (3) @(negedge clk);
    msg_req = 1'b0;
    push(32'h0, 0, 0, 0);
    push(S2,    0, 0, 0);
    push(S2,    0, 0, 0);
    #1 rst = 1'b1;
    wait_cyc(95);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg8_disp_sched.md
Name: seg8_disp_sched

Overview:
- Scheduler and arbiter for the shared 8-digit multiplexed 7-segment display.
- Paces digit refresh with a prescaler and inserts a blanking interval at each digit change to suppress ghosting.
- Shares the display between two requesters: the score source (default owner, always present) and a message source (request/ack handshake, timed ownership).
- Drives the digit index and 4-bit value into the existing hex-decoder/digit-mux datapath.

Parameters:
- CLK_DIV, 1000: clk cycles per digit slot (≥2).
- BLANK_CYC, 50: cycles at the start of each slot with digit_en low (1 ≤ BLANK_CYC < CLK_DIV).
- MSG_FRAMES, 60: full 8-digit frames a granted message stays on screen (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- score_val  in  32  score digits, nibble k = digit k (digit 0 = [3:0])
- msg_val  in  32  message digits, same packing
- msg_req  in  1  message request, level
- msg_abort  in  1  end current message early, level
- msg_ack  out  1  one-cycle pulse: request granted
- msg_done  out  1  one-cycle pulse: message ownership ended
- msg_active  out  1  high while message owns the display
- digit_sel  out  3  digit index to datapath
- digit_val  out  4  nibble for selected digit
- digit_en  out  1  high = digit drive enabled, low = blanked

Behaviour:
- Reset (rst=0, async) values: digit_sel=0, digit_val=0, digit_en=0, msg_ack=0, msg_done=0, msg_active=0, prescaler=0, frame counter=0, snapshot=0, FSM=SCORE.
- Prescaler counts 0..CLK_DIV-1 and wraps. Slot tick = prescaler at CLK_DIV-1.
- On a slot tick, digit_sel increments modulo 8 (7→0 wraps).
- digit_en is 0 while prescaler < BLANK_CYC and 1 otherwise. All outputs are registered.
- Frame boundary is the slot tick where digit_sel goes 7→0.
- At each frame boundary, the 32-bit snapshot is loaded from the source that owns the next frame. This prevents tearing mid-frame.
- digit_val = snapshot nibble[digit_sel], updated in the same cycle as digit_sel.
- After reset, the first frame shows snapshot=0 until the first boundary.
- FSM states:
  - SCORE: score owns the display. msg_req=1 → PEND.
  - PEND: wait for frame boundary. At the boundary: load snapshot from msg_val, pulse msg_ack, set msg_active=1, frame counter=MSG_FRAMES → MSG. If msg_req drops before the boundary → SCORE (no ack).
  - MSG: decrement frame counter at each frame boundary. When counter reaches 0, or when msg_abort was seen high since the last boundary: at that boundary load snapshot from score_val, pulse msg_done, clear msg_active → HOLD.
  - HOLD: wait for msg_req=0 → SCORE. This prevents an immediate re-grant from a stuck request.
- Snapshot sourcing: during MSG, snapshot reloads msg_val at every boundary (message may animate). During SCORE, PEND and HOLD, it reloads score_val.
- msg_abort in SCORE, PEND or HOLD is ignored.
- If msg_abort and the final count occur at the same boundary, exactly one msg_done pulse is issued.
- msg_req is ignored while in MSG and HOLD.
- Mid-operation reset returns immediately to the reset values. No msg_done is issued for the cut-off message.
- Ownership switches occur only at frame boundaries. No partial frame ever mixes sources.

Test Plan:
- Parameters for the bench: CLK_DIV=4, BLANK_CYC=1, MSG_FRAMES=2 (frame = 32 cycles).
- Reset release, score_val=32'h87654321: digit_sel steps 0..7 every 4 cycles. digit_en pattern per slot is 0,1,1,1. From the 2nd frame, digit_val = 1,2,...,8 for sel 0..7.
- msg_req raised mid-frame, msg_val=32'hAAAAAAAA: msg_ack pulses exactly at the next 7→0 boundary. Exactly 2 frames show A on all digits. msg_done pulses at the following boundary. Score resumes in the same cycle.
- msg_req held high through msg_done: no second msg_ack until msg_req has been low for ≥1 cycle and a boundary follows.
- msg_abort pulsed during the 1st message frame: msg_done at the end of that frame, one pulse only, and msg_active falls with it.
- msg_req raised then dropped before the boundary: no msg_ack, score frames uninterrupted.
- rst asserted mid-message: all outputs return to reset values asynchronously. After release, SCORE state with no msg_done.
